// File: rtl/mask_pipe_arbiter.sv
// mask_pipe_arbiter
//   Shares one fixed-latency mask datapath (shifter -> mask -> unshifter)
//   between N_REQ requesters. Requests are granted round-robin, and the
//   winner's operand and mask are driven into the datapath. A tag pipeline
//   with the same depth as the datapath carries the owner id of each
//   operation, so every result comes back on the response port with the
//   right requester index. Backpressure on the response port freezes both
//   the datapath and the tag pipeline. A flush/drain handshake lets
//   software quiesce the unit.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester request valid             [N_REQ]
//   req_ready     per-requester accept, one-hot or zero    [N_REQ]
//   req_data      per-requester operand, i at [i*WIDTH +: WIDTH]
//   req_mask      per-requester mask bit                   [N_REQ]
//   dp_en         datapath enable (low while the response port stalls)
//   dp_in         datapath operand (zero on bubbles)
//   dp_mask       datapath mask bit (zero on bubbles)
//   dp_out        datapath result
//   rsp_valid     result valid
//   rsp_ready     result sink ready
//   rsp_id        requester index that owns the result
//   rsp_data      result, taken straight from dp_out
//   flush         level request to stop accepting and drain
//   idle          pipeline empty and halted
//   inflight      number of operations in flight
module mask_pipe_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int CHUNK   = 3,
    parameter int LATENCY = 2,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*WIDTH-1:0]         req_data,
    input  logic [N_REQ-1:0]               req_mask,
    output logic                           dp_en,
    output logic [WIDTH-1:0]               dp_in,
    output logic                           dp_mask,
    input  logic [WIDTH-1:0]               dp_out,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [WIDTH-1:0]               rsp_data,
    input  logic                           flush,
    output logic                           idle,
    output logic [$clog2(LATENCY+1)-1:0]   inflight
);

    localparam int IF_W = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // The tag pipeline depth must match the datapath built with this CHUNK.
    generate
        if (LATENCY < 1 || LATENCY != ((WIDTH + CHUNK - 1) / CHUNK) - 1) begin : g_cfg_err
            $error("mask_pipe_arbiter: LATENCY does not match WIDTH/CHUNK");
        end
    endgenerate

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [IF_W-1:0] inflight_q, inflight_d;
    logic [LATENCY-1:0] vld_q;
    logic [ID_W-1:0] id_q [LATENCY];

    logic            stall;
    logic            hs;
    logic            issue;
    logic            found;
    logic [ID_W-1:0] grant_id;
    logic [WIDTH-1:0] data_arr [N_REQ];

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_unpack
            assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign rsp_valid = vld_q[LATENCY-1];
    assign rsp_id    = id_q[LATENCY-1];
    assign rsp_data  = dp_out;
    assign stall     = rsp_valid & ~rsp_ready;
    assign hs        = rsp_valid & rsp_ready;
    assign dp_en     = ~stall;
    assign idle      = (state_q == ST_HALT);
    assign inflight  = inflight_q;

    // Round-robin search starting at rr_q, wrapping at N_REQ.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx      = 0;
        cand     = '0;
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = idx[ID_W-1:0];
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
    end

    // Reset also masks issue so nothing is accepted while it is held.
    assign issue = ~rst & (state_q == ST_RUN) & ~stall & found;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign dp_in   = issue ? data_arr[grant_id] : '0;
    assign dp_mask = issue & req_mask[grant_id];

    always_comb begin
        rr_d = rr_q;
        if (issue) begin
            rr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        case ({issue, hs})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_q == '0 && !rsp_valid) state_d = ST_HALT;
            ST_HALT:  if (!flush) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            rr_q       <= '0;
            inflight_q <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            if (dp_en) begin
                vld_q[0] <= issue;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end
    end

    // Ids need no reset: they are only observed alongside a set valid bit.
    always_ff @(posedge clk) begin
        if (dp_en) begin
            id_q[0] <= grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                id_q[i] <= id_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mask_pipe_arbiter.sv
module tb_mask_pipe_arbiter;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int CHUNK   = 3;
    localparam int LATENCY = 2;
    localparam int ID_W    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_mask;
    logic                   dp_en;
    logic [WIDTH-1:0]       dp_in;
    logic                   dp_mask;
    logic [WIDTH-1:0]       dp_out;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic                   flush;
    logic                   idle;
    logic [1:0]             inflight;

    always #5 clk = ~clk;

    mask_pipe_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .CHUNK(CHUNK), .LATENCY(LATENCY), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mask(req_mask),
        .dp_en(dp_en), .dp_in(dp_in), .dp_mask(dp_mask), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .flush(flush), .idle(idle), .inflight(inflight)
    );

    // Behavioural two-stage mask datapath: out = in & {WIDTH{mask}}.
    logic [WIDTH-1:0] dps0, dps1;
    always_ff @(posedge clk) begin
        if (dp_en) begin
            dps0 <= dp_in & {WIDTH{dp_mask}};
            dps1 <= dps0;
        end
    end
    assign dp_out = dps1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Compares every visible output against the expected values for one cycle.
    task automatic chk_cyc(input string tag, input logic [3:0] e_rdy, input logic e_vld,
                           input logic [1:0] e_id, input logic [7:0] e_dat,
                           input logic [1:0] e_inf, input logic e_idle, input logic e_en);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(e_rdy));
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(e_vld));
        if (e_vld) begin
            chk({tag, ".rsp_id"},   32'(rsp_id),   32'(e_id));
            chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(e_dat));
        end
        chk({tag, ".inflight"}, 32'(inflight), 32'(e_inf));
        chk({tag, ".idle"},     32'(idle),     32'(e_idle));
        chk({tag, ".dp_en"},    32'(dp_en),    32'(e_en));
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       rr;
        logic [3:0] rdy;
        logic       vld;
        logic [1:0] id;
        logic [7:0] dat;
        logic [1:0] inf;
        logic       en;
    } vec_t;

    function automatic vec_t V(input logic [3:0] rv, input logic rr, input logic [3:0] rdy,
                               input logic vld, input logic [1:0] id, input logic [7:0] dat,
                               input logic [1:0] inf, input logic en);
        vec_t v;
        v.rv = rv; v.rr = rr; v.rdy = rdy; v.vld = vld;
        v.id = id; v.dat = dat; v.inf = inf; v.en = en;
        return v;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fixed operands: A5 (mask 1), 3C (mask 1), F0 (mask 0), 0F (mask 1).
    localparam logic [31:0] FIX_DATA = {8'h0F, 8'hF0, 8'h3C, 8'hA5};
    localparam logic [3:0]  FIX_MASK = 4'b1011;

    vec_t tbl [15];
    logic [1:0] qid [$];
    logic [7:0] qdat [$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = V(4'b0001, 1, 4'b0001, 0, 0, 8'h00, 0, 1);
        tbl[1]  = V(4'b0000, 1, 4'b0000, 0, 0, 8'h00, 1, 1);
        tbl[2]  = V(4'b0000, 1, 4'b0000, 1, 0, 8'hA5, 1, 1);
        tbl[3]  = V(4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0, 1);
        tbl[4]  = V(4'b1111, 1, 4'b0010, 0, 0, 8'h00, 0, 1);
        tbl[5]  = V(4'b1111, 1, 4'b0100, 0, 0, 8'h00, 1, 1);
        tbl[6]  = V(4'b1111, 1, 4'b1000, 1, 1, 8'h3C, 2, 1);
        tbl[7]  = V(4'b1111, 1, 4'b0001, 1, 2, 8'h00, 2, 1);
        tbl[8]  = V(4'b1111, 0, 4'b0000, 1, 3, 8'h0F, 2, 0);
        tbl[9]  = V(4'b1111, 0, 4'b0000, 1, 3, 8'h0F, 2, 0);
        tbl[10] = V(4'b1111, 0, 4'b0000, 1, 3, 8'h0F, 2, 0);
        tbl[11] = V(4'b1111, 1, 4'b0010, 1, 3, 8'h0F, 2, 1);
        tbl[12] = V(4'b0000, 1, 4'b0000, 1, 0, 8'hA5, 2, 1);
        tbl[13] = V(4'b0000, 1, 4'b0000, 1, 1, 8'h3C, 1, 1);
        tbl[14] = V(4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0, 1);

        req_data  = FIX_DATA;
        req_mask  = FIX_MASK;
        rst       = 1'b1;
        req_valid = 4'b1111;
        flush     = 1'b0;
        rsp_ready = 1'b1;

        // Outputs while reset is held, with all requesters asking.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_cyc("reset", 4'b0000, 0, 0, 8'h00, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;

        // Single op, rotation, and 3-cycle response stall.
        for (int r = 0; r < 15; r++) begin
            req_valid = tbl[r].rv;
            rsp_ready = tbl[r].rr;
            #1;
            chk_cyc($sformatf("tbl%0d", r), tbl[r].rdy, tbl[r].vld, tbl[r].id,
                    tbl[r].dat, tbl[r].inf, 1'b0, tbl[r].en);
            @(negedge clk);
        end

        // Flush with a full pipeline, drain, halt, resume.
        do_reset();
        req_valid = 4'b1111;
        #1; chk_cyc("fl0", 4'b0001, 0, 0, 8'h00, 0, 0, 1); @(negedge clk);
        #1; chk_cyc("fl1", 4'b0010, 0, 0, 8'h00, 1, 0, 1); @(negedge clk);
        flush = 1'b1;
        #1; chk_cyc("fl2", 4'b0100, 1, 0, 8'hA5, 2, 0, 1); @(negedge clk);
        #1; chk_cyc("fl3", 4'b0000, 1, 1, 8'h3C, 2, 0, 1); @(negedge clk);
        #1; chk_cyc("fl4", 4'b0000, 1, 2, 8'h00, 1, 0, 1); @(negedge clk);
        #1; chk_cyc("fl5", 4'b0000, 0, 0, 8'h00, 0, 0, 1); @(negedge clk);
        #1; chk_cyc("fl6", 4'b0000, 0, 0, 8'h00, 0, 1, 1); @(negedge clk);
        flush = 1'b0;
        #1; chk_cyc("fl7", 4'b0000, 0, 0, 8'h00, 0, 1, 1); @(negedge clk);
        #1; chk_cyc("fl8", 4'b1000, 0, 0, 8'h00, 0, 0, 1); @(negedge clk);

        // Reset with two operations in flight.
        #1; chk_cyc("rs0", 4'b0001, 0, 0, 8'h00, 1, 0, 1); @(negedge clk);
        rst = 1'b1;
        #1; chk_cyc("rs1", 4'b0000, 1, 3, 8'h0F, 2, 0, 1); @(negedge clk);
        rst = 1'b0;
        #1; chk_cyc("rs2", 4'b0001, 0, 0, 8'h00, 0, 0, 1); @(negedge clk);
        req_valid = 4'b0000;
        #1; chk_cyc("rs3", 4'b0000, 0, 0, 8'h00, 1, 0, 1); @(negedge clk);
        #1; chk_cyc("rs4", 4'b0000, 1, 0, 8'hA5, 1, 0, 1); @(negedge clk);

        // Random traffic against a scoreboard and a round-robin model.
        do_reset();
        begin
            logic [1:0] mrr;
            logic [1:0] eg;
            logic [1:0] j;
            logic       found;
            logic       stl;
            logic [3:0] erdy;
            mrr = 2'd0;
            for (int c = 0; c < 300; c++) begin
                req_valid = 4'($urandom_range(0, 15));
                req_data  = $urandom();
                req_mask  = 4'($urandom_range(0, 15));
                rsp_ready = ($urandom_range(0, 3) != 0);
                #1;
                chk("rnd.inflight", 32'(inflight), 32'(qid.size()));
                if (rsp_valid && rsp_ready) begin
                    if (qid.size() == 0) begin
                        chk("rnd.unexpected_rsp", 32'(1), 32'(0));
                    end else begin
                        chk("rnd.rsp_id",   32'(rsp_id),   32'(qid.pop_front()));
                        chk("rnd.rsp_data", 32'(rsp_data), 32'(qdat.pop_front()));
                    end
                end
                stl   = rsp_valid & ~rsp_ready;
                found = 1'b0;
                eg    = 2'd0;
                for (int k = 0; k < 4; k++) begin
                    j = 2'(int'(mrr) + k);
                    if (!found && req_valid[j]) begin
                        found = 1'b1;
                        eg    = j;
                    end
                end
                erdy = (found && !stl) ? (4'b0001 << eg) : 4'b0000;
                chk("rnd.req_ready", 32'(req_ready), 32'(erdy));
                if (found && !stl) begin
                    qid.push_back(eg);
                    qdat.push_back(req_data[eg*8 +: 8] & {8{req_mask[eg]}});
                    mrr = eg + 2'd1;
                end
                @(negedge clk);
            end
            // Drain everything still in flight.
            req_valid = '0;
            rsp_ready = 1'b1;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (rsp_valid) begin
                    if (qid.size() == 0) begin
                        chk("drain.unexpected_rsp", 32'(1), 32'(0));
                    end else begin
                        chk("drain.rsp_id",   32'(rsp_id),   32'(qid.pop_front()));
                        chk("drain.rsp_data", 32'(rsp_data), 32'(qdat.pop_front()));
                    end
                end
                @(negedge clk);
            end
            chk("drain.lost_results", 32'(qid.size()), 32'(0));
            #1;
            chk("drain.inflight", 32'(inflight), 32'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
